// File: rtl/pmod_als_spi_receiver.sv
// rtl/pmod_als_spi_receiver.sv - SPI master reading the PMOD ALS (ADC081S021) light sensor
//
// Purpose: generates a free-running sck, frames 16-bit conversions with cs,
// and presents the 8-bit light value (packet bits [11:4]) with a one-clk
// valid pulse. Conversions run single-shot on start, or periodically while
// auto_en is high.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        single-clk conversion request (one extra request queued while busy)
//   auto_en      level; enables periodic conversions every AUTO_PERIOD idle sck periods
//   cs, sck      sensor chip select (active low) and serial clock
//   sdo          sensor serial data, asynchronous to clk
//   value/valid  last captured light value and its one-clk update strobe
//   busy         high from request accept until the frame and its cs-high gap end
//   frame_err    only with PMOD_ALS_FRAME_CHECK_EN: nonzero padding bits seen
//
// Optional feature macro: PMOD_ALS_FRAME_CHECK_EN

module pmod_als_spi_receiver #(
  parameter int CLK_DIV     = 4,
  parameter int AUTO_PERIOD = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       auto_en,
  output logic       cs,
  output logic       sck,
  input  logic       sdo,
  output logic [7:0] value,
  output logic       valid,
  output logic       busy
`ifdef PMOD_ALS_FRAME_CHECK_EN
  ,
  output logic       frame_err
`endif
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              sck_q, sck_d;
  logic              sdo_m_q, sdo_s_q;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       shift_q, shift_d;
  logic              cs_q, cs_d;
  logic [7:0]        value_q, value_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              pending_q, pending_d;
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic              tick, rise, auto_expired, req;
`ifdef PMOD_ALS_FRAME_CHECK_EN
  logic              frame_err_q, frame_err_d;
`else
  logic              unused_pad;
  assign unused_pad = ^{shift_q[15], shift_q[3:0]};
`endif

  // sck toggles every CLK_DIV clks; a rise is the toggle taken while sck is low.
  always_comb begin
    tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    sck_d     = tick ? ~sck_q : sck_q;
    rise      = tick & ~sck_q;
  end

  assign auto_expired = auto_en && (auto_cnt_q == AUTO_W'(AUTO_PERIOD));
  assign req          = start || auto_expired;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    cs_d       = cs_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    pending_d  = pending_q;
    auto_cnt_d = auto_cnt_q;
`ifdef PMOD_ALS_FRAME_CHECK_EN
    frame_err_d = frame_err_q;
`endif

    // Timer only advances while idle and saturates so expiry stays visible.
    if (!auto_en) begin
      auto_cnt_d = '0;
    end else if (state_q == ST_IDLE && rise && auto_cnt_q != AUTO_W'(AUTO_PERIOD)) begin
      auto_cnt_d = auto_cnt_q + 1'b1;
    end

    // One-deep request queue; further starts while pending are dropped.
    if (state_q != ST_IDLE && start) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (rise) begin
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          shift_d = {shift_q[14:0], sdo_s_q};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            cs_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        value_d    = shift_q[11:4];
        valid_d    = 1'b1;
        auto_cnt_d = '0;
        cnt_d      = '0;
        state_d    = ST_GAP;
`ifdef PMOD_ALS_FRAME_CHECK_EN
        frame_err_d = (shift_q[15:12] != 4'h0) || (shift_q[3:0] != 4'h0);
`endif
      end
      ST_GAP: begin
        // Two rises with cs high let the sensor reload its shift buffer.
        if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            // A start landing on this exact clk is honoured rather than lost.
            if (pending_q || start) begin
              pending_d = 1'b0;
              state_d   = ST_ARM;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      sck_q      <= 1'b1;
      sdo_m_q    <= 1'b0;
      sdo_s_q    <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      cs_q       <= 1'b1;
      value_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      auto_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      sck_q      <= sck_d;
      sdo_m_q    <= sdo;
      sdo_s_q    <= sdo_m_q;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      cs_q       <= cs_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      auto_cnt_q <= auto_cnt_d;
    end
  end

`ifdef PMOD_ALS_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end
  assign frame_err = frame_err_q;
`endif

  assign cs    = cs_q;
  assign sck   = sck_q;
  assign value = value_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_pmod_als_spi_receiver.sv
// tb/tb_pmod_als_spi_receiver.sv - directed self-checking bench for pmod_als_spi_receiver

module tb_pmod_als_spi_receiver;

  localparam int CLK_DIV     = 4;
  localparam int AUTO_PERIOD = 8;
  // GAP(2) + auto wait(8) + ARM(1) + SHIFT(16) sck periods, in clks
  localparam int AUTO_INTERVAL = (2 + AUTO_PERIOD + 1 + 16) * 2 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       cs, sck;
  logic       sdo = 1'b0;
  logic [7:0] value;
  logic       valid, busy;
`ifdef PMOD_ALS_FRAME_CHECK_EN
  logic       frame_err;
`endif

  pmod_als_spi_receiver #(.CLK_DIV(CLK_DIV), .AUTO_PERIOD(AUTO_PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en),
    .cs(cs), .sck(sck), .sdo(sdo), .value(value), .valid(valid), .busy(busy)
`ifdef PMOD_ALS_FRAME_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Sensor stub: reloads while cs is high, shifts MSB-first on sck falls.
  logic [15:0] pkt = 16'h0000;
  int          idx = 0;
  always @(negedge sck) begin
    if (cs) idx = 0;
    else if (idx < 16) begin
      sdo = pkt[15 - idx];
      idx = idx + 1;
    end
  end

  // Monitor, sampled on the falling clk edge.
  int   cyc = 0, rise_lo = 0, cs_fall = 0, valid_cnt = 0;
  int   vt[$];
  logic [7:0] vv[$];
  logic ferr_q[$];
  logic sck_prev = 1'b1, cs_prev = 1'b1;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sck && !sck_prev && !cs) rise_lo = rise_lo + 1;
    if (!cs && cs_prev) cs_fall = cs_fall + 1;
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      vt.push_back(cyc);
      vv.push_back(value);
`ifdef PMOD_ALS_FRAME_CHECK_EN
      ferr_q.push_back(frame_err);
`else
      ferr_q.push_back(1'b0);
`endif
    end
    sck_prev = sck;
    cs_prev  = cs;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (valid_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic one_frame(input logic [7:0] v, input string tag);
    int bv;
    bit ok;
    bv  = valid_cnt;
    pkt = {4'h0, v, 4'h0};
    pulse_start();
    wait_valid(bv + 1, 200, ok);
    check({tag, "_valid_seen"}, ok, 1);
    wait_idle(100, ok);
    repeat (4) tick();
    check({tag, "_value"}, value, v);
    check({tag, "_one_valid"}, valid_cnt - bv, 1);
  endtask

  initial begin
    int  bv, br, bc, t0;
    bit  ok;

    // Reset state
    repeat (3) tick();
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 1);
    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // 1: single frame 0xAB
    pkt = 16'h0AB0;
    bv = valid_cnt; br = rise_lo;
    pulse_start();
    t0 = cyc;
    check("t1_busy_rise", busy, 1);
    wait_valid(bv + 1, 200, ok);
    check("t1_valid_seen", ok, 1);
    check("t1_latency_ok", (vt[bv] - t0) <= 2 + 2 * CLK_DIV + 32 * CLK_DIV, 1);
    check("t1_value", vv[bv], 8'hAB);
    wait_idle(100, ok);
    check("t1_busy_fall", ok, 1);
    check("t1_cs_high", cs, 1);
    check("t1_rises_cs_low", rise_lo - br, 16);
    check("t1_one_valid", valid_cnt - bv, 1);

    // 2: consecutive 0x00 then 0xFF
    one_frame(8'h00, "t2a");
    one_frame(8'hFF, "t2b");

    // 3: periodic conversions
    pkt = 16'h05A0;
    bv = valid_cnt;
    auto_en = 1'b1;
    wait_valid(bv + 3, 1200, ok);
    auto_en = 1'b0;
    check("t3_three_valid", ok, 1);
    if (ok) begin
      check("t3_interval1", vt[bv + 1] - vt[bv], AUTO_INTERVAL);
      check("t3_interval2", vt[bv + 2] - vt[bv + 1], AUTO_INTERVAL);
      check("t3_value0", vv[bv], 8'h5A);
      check("t3_value2", vv[bv + 2], 8'h5A);
    end
    wait_idle(100, ok);
    check("t3_idle_after_auto_off", ok, 1);
    bc = cs_fall; bv = valid_cnt;
    repeat (400) tick();
    check("t3_no_cs_after_off", cs_fall - bc, 0);
    check("t3_no_valid_after_off", valid_cnt - bv, 0);

    // 4: three starts in one frame -> two frames
    pkt = 16'h03C0;
    bv = valid_cnt; bc = cs_fall;
    pulse_start();
    repeat (20) tick();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    wait_valid(bv + 2, 400, ok);
    check("t4_two_valid_seen", ok, 1);
    wait_idle(200, ok);
    repeat (300) tick();
    check("t4_valid_count", valid_cnt - bv, 2);
    check("t4_frame_count", cs_fall - bc, 2);
    check("t4_value", value, 8'h3C);

    // 5: reset mid-frame
    pkt = 16'h0AB0;
    bv = valid_cnt; br = rise_lo;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rise_lo - br >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_reached_bit9", ok, 1);
    rst_n = 1'b0;
    #1;
    check("t5_cs", cs, 1);
    check("t5_sck", sck, 1);
    check("t5_value", value, 0);
    check("t5_busy", busy, 0);
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t5_no_valid", valid_cnt - bv, 0);
    one_frame(8'hAB, "t5_after");

`ifdef PMOD_ALS_FRAME_CHECK_EN
    // 6: padding check
    pkt = 16'h1AB0;
    bv = valid_cnt;
    pulse_start();
    wait_valid(bv + 1, 200, ok);
    check("t6_bad_seen", ok, 1);
    if (ok) begin
      check("t6_bad_ferr", ferr_q[bv], 1);
      check("t6_bad_value", vv[bv], 8'hAB);
    end
    wait_idle(100, ok);
    pkt = 16'h0AB0;
    bv = valid_cnt;
    pulse_start();
    wait_valid(bv + 1, 200, ok);
    check("t6_good_seen", ok, 1);
    if (ok) check("t6_good_ferr", ferr_q[bv], 0);
    wait_idle(100, ok);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
